// File: rtl/mini_src_pkg.sv
// Shared encodings for the Mini SRC control unit: opcodes, sequencer states,
// opcode classes and the flat control-word layout.
package mini_src_pkg;

    localparam logic [4:0] OpLd   = 5'b00000;
    localparam logic [4:0] OpLdi  = 5'b00001;
    localparam logic [4:0] OpSt   = 5'b00010;
    localparam logic [4:0] OpAdd  = 5'b00011;
    localparam logic [4:0] OpSub  = 5'b00100;
    localparam logic [4:0] OpAnd  = 5'b00101;
    localparam logic [4:0] OpOr   = 5'b00110;
    localparam logic [4:0] OpShr  = 5'b00111;
    localparam logic [4:0] OpShra = 5'b01000;
    localparam logic [4:0] OpShl  = 5'b01001;
    localparam logic [4:0] OpRor  = 5'b01010;
    localparam logic [4:0] OpRol  = 5'b01011;
    localparam logic [4:0] OpAddi = 5'b01100;
    localparam logic [4:0] OpAndi = 5'b01101;
    localparam logic [4:0] OpOri  = 5'b01110;
    localparam logic [4:0] OpMul  = 5'b01111;
    localparam logic [4:0] OpDiv  = 5'b10000;
    localparam logic [4:0] OpNeg  = 5'b10001;
    localparam logic [4:0] OpNot  = 5'b10010;
    localparam logic [4:0] OpBr   = 5'b10011;
    localparam logic [4:0] OpJr   = 5'b10100;
    localparam logic [4:0] OpJal  = 5'b10101;
    localparam logic [4:0] OpIn   = 5'b10110;
    localparam logic [4:0] OpOut  = 5'b10111;
    localparam logic [4:0] OpMfhi = 5'b11000;
    localparam logic [4:0] OpMflo = 5'b11001;
    localparam logic [4:0] OpNop  = 5'b11010;
    localparam logic [4:0] OpHalt = 5'b11011;

    localparam logic [4:0] AluAdd = OpAdd;

    typedef enum logic [3:0] {
        StRst, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StT7, StHalted
    } state_e;

    typedef struct packed {
        logic alu, imm, muldiv, unary, ld, ldi, st, br;
        logic jr, jal, cls_in, cls_out, mfhi, mflo, nop, halt;
    } op_class_t;

    typedef struct packed {
        logic gra, grb, grc, r_in, r_out, ba_out, link;
        logic p_en, ir_en, y_en, z_en, mar_en, mdr_en, hi_en, lo_en, out_port_en, con_en;
        logic p_sel, zlo_sel, zhi_sel, hi_sel, lo_sel, mdr_sel, in_port_sel, c_sel;
        logic inc_pc, read, write;
        logic [4:0] alu_op;
        logic run, clr;
    } ctrl_t;

endpackage

// File: rtl/control_unit_if.sv
// Control-unit side bundle: IR/condition/stop inputs and every datapath strobe.
interface control_unit_if;
    logic        stop;
    logic [31:0] ir;
    logic        con_ff;
    logic Gra, Grb, Grc, Rin, Rout, BAout, link;
    logic Pen, IRen, Yen, Zen, MARen, MDRen, HIen, LOen, Out_Porten, con_en;
    logic Pselect, ZLOselect, ZHIselect, HIselect, LOselect, MDRselect, In_Portselect, Cselect;
    logic IncPC, Read, Write;
    logic [4:0] alu_op;
    logic run, clr;

    modport master (
        input  stop, ir, con_ff,
        output Gra, Grb, Grc, Rin, Rout, BAout, link,
        output Pen, IRen, Yen, Zen, MARen, MDRen, HIen, LOen, Out_Porten, con_en,
        output Pselect, ZLOselect, ZHIselect, HIselect, LOselect, MDRselect, In_Portselect,
        output Cselect, IncPC, Read, Write, alu_op, run, clr
    );

    modport slave (
        output stop, ir, con_ff,
        input  Gra, Grb, Grc, Rin, Rout, BAout, link,
        input  Pen, IRen, Yen, Zen, MARen, MDRen, HIen, LOen, Out_Porten, con_en,
        input  Pselect, ZLOselect, ZHIselect, HIselect, LOselect, MDRselect, In_Portselect,
        input  Cselect, IncPC, Read, Write, alu_op, run, clr
    );
endinterface

// File: rtl/control_unit_op_class_decode.sv
// Opcode to instruction-class one-hot; reserved opcodes fall into the nop class.
module op_class_decode
    import mini_src_pkg::*;
(
    input  logic [4:0] op_i,
    output op_class_t  cls_o
);
    always_comb begin
        cls_o = '0;
        case (op_i)
            OpAdd, OpSub, OpAnd, OpOr, OpShr,
            OpShra, OpShl, OpRor, OpRol: cls_o.alu     = 1'b1;
            OpAddi, OpAndi, OpOri:       cls_o.imm     = 1'b1;
            OpMul, OpDiv:                cls_o.muldiv  = 1'b1;
            OpNeg, OpNot:                cls_o.unary   = 1'b1;
            OpLd:                        cls_o.ld      = 1'b1;
            OpLdi:                       cls_o.ldi     = 1'b1;
            OpSt:                        cls_o.st      = 1'b1;
            OpBr:                        cls_o.br      = 1'b1;
            OpJr:                        cls_o.jr      = 1'b1;
            OpJal:                       cls_o.jal     = 1'b1;
            OpIn:                        cls_o.cls_in  = 1'b1;
            OpOut:                       cls_o.cls_out = 1'b1;
            OpMfhi:                      cls_o.mfhi    = 1'b1;
            OpMflo:                      cls_o.mflo    = 1'b1;
            OpHalt:                      cls_o.halt    = 1'b1;
            default:                     cls_o.nop     = 1'b1;
        endcase
    end
endmodule

// File: rtl/control_unit.sv
// Mini SRC hardwired sequencer: fetch T0-T2, class-dependent execute T3-T7,
// with run/halt ownership. Strobes are a Moore decode of the step register.
module control_unit
    import mini_src_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    control_unit_if.master bus
);
    state_e    state_q, state_d;
    op_class_t cls;
    ctrl_t     c;
    logic [4:0] op;
    logic       unused_ir;

    assign op        = bus.ir[31:27];
    assign unused_ir = ^bus.ir[26:0];

    op_class_decode u_decode (.op_i(op), .cls_o(cls));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= StRst;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRst:    state_d = StT0;
            StT0:     state_d = StT1;
            StT1:     state_d = StT2;
            StT2:     state_d = cls.halt ? StHalted : (cls.nop ? StT0 : StT3);
            StT3:     state_d = (cls.jr | cls.cls_in | cls.cls_out | cls.mfhi | cls.mflo)
                                ? StT0 : StT4;
            StT4:     state_d = (cls.jal | cls.unary) ? StT0 : StT5;
            StT5:     state_d = (cls.alu | cls.imm | cls.ldi) ? StT0 : StT6;
            StT6:     state_d = (cls.muldiv | cls.br) ? StT0 : StT7;
            StT7:     state_d = StT0;
            StHalted: state_d = StHalted;
            default:  state_d = StRst;
        endcase
        // Instruction boundary: a pending stop diverts the next fetch into halt.
        if (state_d == StT0 && bus.stop) state_d = StHalted;
    end

    always_comb begin
        c     = '0;
        c.run = state_q inside {StT0, StT1, StT2, StT3, StT4, StT5, StT6, StT7};
        unique case (state_q)
            StRst: c.clr = 1'b1;
            StT0: begin
                c.p_sel = 1'b1; c.mar_en = 1'b1; c.inc_pc = 1'b1; c.z_en = 1'b1;
                c.alu_op = AluAdd;
            end
            StT1: begin c.zlo_sel = 1'b1; c.p_en = 1'b1; c.read = 1'b1; c.mdr_en = 1'b1; end
            StT2: begin c.mdr_sel = 1'b1; c.ir_en = 1'b1; end
            StT3: begin
                if (cls.alu | cls.imm)         begin c.grb = 1'b1; c.r_out = 1'b1; c.y_en = 1'b1; end
                if (cls.muldiv)                begin c.gra = 1'b1; c.r_out = 1'b1; c.y_en = 1'b1; end
                if (cls.unary) begin
                    c.grb = 1'b1; c.r_out = 1'b1; c.z_en = 1'b1; c.alu_op = op;
                end
                if (cls.ld | cls.ldi | cls.st) begin c.grb = 1'b1; c.ba_out = 1'b1; c.y_en = 1'b1; end
                if (cls.br)      begin c.gra = 1'b1; c.r_out = 1'b1; c.con_en = 1'b1; end
                if (cls.jr)      begin c.gra = 1'b1; c.r_out = 1'b1; c.p_en = 1'b1; end
                if (cls.jal)     begin c.p_sel = 1'b1; c.link = 1'b1; c.r_in = 1'b1; end
                if (cls.cls_in)  begin c.in_port_sel = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
                if (cls.cls_out) begin c.gra = 1'b1; c.r_out = 1'b1; c.out_port_en = 1'b1; end
                if (cls.mfhi)    begin c.hi_sel = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
                if (cls.mflo)    begin c.lo_sel = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
            end
            StT4: begin
                if (cls.alu)    begin c.grc = 1'b1; c.r_out = 1'b1; c.z_en = 1'b1; c.alu_op = op; end
                if (cls.imm)    begin c.c_sel = 1'b1; c.z_en = 1'b1; c.alu_op = op; end
                if (cls.muldiv) begin c.grb = 1'b1; c.r_out = 1'b1; c.z_en = 1'b1; c.alu_op = op; end
                if (cls.unary)  begin c.zlo_sel = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
                if (cls.ld | cls.ldi | cls.st) begin
                    c.c_sel = 1'b1; c.z_en = 1'b1; c.alu_op = AluAdd;
                end
                if (cls.br)     begin c.p_sel = 1'b1; c.y_en = 1'b1; end
                if (cls.jal)    begin c.gra = 1'b1; c.r_out = 1'b1; c.p_en = 1'b1; end
            end
            StT5: begin
                if (cls.alu | cls.imm | cls.ldi) begin c.zlo_sel = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
                if (cls.muldiv)      begin c.zlo_sel = 1'b1; c.lo_en = 1'b1; end
                if (cls.ld | cls.st) begin c.zlo_sel = 1'b1; c.mar_en = 1'b1; end
                if (cls.br)          begin c.c_sel = 1'b1; c.z_en = 1'b1; c.alu_op = AluAdd; end
            end
            StT6: begin
                if (cls.muldiv)          begin c.zhi_sel = 1'b1; c.hi_en = 1'b1; end
                if (cls.ld)              begin c.read = 1'b1; c.mdr_en = 1'b1; end
                if (cls.st)              begin c.gra = 1'b1; c.r_out = 1'b1; c.mdr_en = 1'b1; end
                if (cls.br & bus.con_ff) begin c.zlo_sel = 1'b1; c.p_en = 1'b1; end
            end
            StT7: begin
                if (cls.ld) begin c.mdr_sel = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
                if (cls.st) c.write = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.Gra = c.gra;             assign bus.Grb = c.grb;
    assign bus.Grc = c.grc;             assign bus.Rin = c.r_in;
    assign bus.Rout = c.r_out;          assign bus.BAout = c.ba_out;
    assign bus.link = c.link;           assign bus.Pen = c.p_en;
    assign bus.IRen = c.ir_en;          assign bus.Yen = c.y_en;
    assign bus.Zen = c.z_en;            assign bus.MARen = c.mar_en;
    assign bus.MDRen = c.mdr_en;        assign bus.HIen = c.hi_en;
    assign bus.LOen = c.lo_en;          assign bus.Out_Porten = c.out_port_en;
    assign bus.con_en = c.con_en;       assign bus.Pselect = c.p_sel;
    assign bus.ZLOselect = c.zlo_sel;   assign bus.ZHIselect = c.zhi_sel;
    assign bus.HIselect = c.hi_sel;     assign bus.LOselect = c.lo_sel;
    assign bus.MDRselect = c.mdr_sel;   assign bus.In_Portselect = c.in_port_sel;
    assign bus.Cselect = c.c_sel;       assign bus.IncPC = c.inc_pc;
    assign bus.Read = c.read;           assign bus.Write = c.write;
    assign bus.alu_op = c.alu_op;       assign bus.run = c.run;
    assign bus.clr = c.clr;
endmodule

// File: tb/tb_control_unit.sv
// Randomized instruction stream checked cycle by cycle against a per-opcode
// microprogram table, with stop, halt and mid-instruction reset injection.
module tb_control_unit;
    logic clk = 1'b0;
    logic reset = 1'b0;
    control_unit_if cu_if ();

    control_unit dut (.clk(clk), .reset(reset), .bus(cu_if));

    always #5 clk = ~clk;

    localparam logic [27:0] GRA = 28'h0000001, GRB = 28'h0000002, GRC = 28'h0000004;
    localparam logic [27:0] RIN = 28'h0000008, ROUT = 28'h0000010, BAOUT = 28'h0000020;
    localparam logic [27:0] LINK = 28'h0000040, PEN = 28'h0000080, IREN = 28'h0000100;
    localparam logic [27:0] YEN = 28'h0000200, ZEN = 28'h0000400, MAREN = 28'h0000800;
    localparam logic [27:0] MDREN = 28'h0001000, HIEN = 28'h0002000, LOEN = 28'h0004000;
    localparam logic [27:0] OPEN = 28'h0008000, CONEN = 28'h0010000, PSEL = 28'h0020000;
    localparam logic [27:0] ZLO = 28'h0040000, ZHI = 28'h0080000, HISEL = 28'h0100000;
    localparam logic [27:0] LOSEL = 28'h0200000, MDRSEL = 28'h0400000, INSEL = 28'h0800000;
    localparam logic [27:0] CSEL = 28'h1000000, INCPC = 28'h2000000, READ = 28'h4000000;
    localparam logic [27:0] WRITE = 28'h8000000;
    localparam logic [4:0]  ADD = 5'd3;

    int total = 0;
    int bad = 0;
    logic [32:0] prog_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [27:0] obs();
        return {cu_if.Write, cu_if.Read, cu_if.IncPC, cu_if.Cselect, cu_if.In_Portselect,
                cu_if.MDRselect, cu_if.LOselect, cu_if.HIselect, cu_if.ZHIselect,
                cu_if.ZLOselect, cu_if.Pselect, cu_if.con_en, cu_if.Out_Porten, cu_if.LOen,
                cu_if.HIen, cu_if.MDRen, cu_if.MARen, cu_if.Zen, cu_if.Yen, cu_if.IRen,
                cu_if.Pen, cu_if.link, cu_if.BAout, cu_if.Rout, cu_if.Rin, cu_if.Grc,
                cu_if.Grb, cu_if.Gra};
    endfunction

    task automatic push(input logic [27:0] f, input logic [4:0] a);
        prog_q.push_back({f, a});
    endtask

    // Reference microprogram: one entry per clock of the instruction.
    task automatic build_prog(input int op, input logic con);
        prog_q.delete();
        push(PSEL | MAREN | INCPC | ZEN, ADD);
        push(ZLO | PEN | READ | MDREN, 5'd0);
        push(MDRSEL | IREN, 5'd0);
        if (op >= 3 && op <= 11) begin
            push(GRB | ROUT | YEN, 5'd0); push(GRC | ROUT | ZEN, 5'(op)); push(ZLO | GRA | RIN, 5'd0);
        end else if (op >= 12 && op <= 14) begin
            push(GRB | ROUT | YEN, 5'd0); push(CSEL | ZEN, 5'(op)); push(ZLO | GRA | RIN, 5'd0);
        end else if (op == 15 || op == 16) begin
            push(GRA | ROUT | YEN, 5'd0); push(GRB | ROUT | ZEN, 5'(op));
            push(ZLO | LOEN, 5'd0); push(ZHI | HIEN, 5'd0);
        end else if (op == 17 || op == 18) begin
            push(GRB | ROUT | ZEN, 5'(op)); push(ZLO | GRA | RIN, 5'd0);
        end else if (op <= 2) begin
            push(GRB | BAOUT | YEN, 5'd0); push(CSEL | ZEN, ADD);
            if (op == 1) push(ZLO | GRA | RIN, 5'd0);
            else begin
                push(ZLO | MAREN, 5'd0);
                if (op == 0) begin push(READ | MDREN, 5'd0); push(MDRSEL | GRA | RIN, 5'd0); end
                else begin push(GRA | ROUT | MDREN, 5'd0); push(WRITE, 5'd0); end
            end
        end else begin
            case (op)
                19: begin
                    push(GRA | ROUT | CONEN, 5'd0); push(PSEL | YEN, 5'd0); push(CSEL | ZEN, ADD);
                    push(con ? (ZLO | PEN) : 28'h0, 5'd0);
                end
                20: push(GRA | ROUT | PEN, 5'd0);
                21: begin push(PSEL | LINK | RIN, 5'd0); push(GRA | ROUT | PEN, 5'd0); end
                22: push(INSEL | GRA | RIN, 5'd0);
                23: push(GRA | ROUT | OPEN, 5'd0);
                24: push(HISEL | GRA | RIN, 5'd0);
                25: push(LOSEL | GRA | RIN, 5'd0);
                default: ;
            endcase
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        cu_if.stop = 1'b0;
        #1;
        check("rst ctrl", {obs(), cu_if.alu_op}, 33'h0);
        check("rst clr/run", {cu_if.clr, cu_if.run}, 2'b10);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst hold clr/run", {cu_if.clr, cu_if.run}, 2'b10);
    endtask

    task automatic run_instr(input int op, input logic con, input int stop_at, input int abort_at);
        build_prog(op, con);
        for (int i = 0; i < prog_q.size(); i++) begin
            @(negedge clk);
            if (i == 0) begin
                cu_if.ir = {5'(op), 27'($urandom)};
                cu_if.con_ff = con;
            end
            if (i == stop_at) cu_if.stop = 1'b1;
            #1;
            check($sformatf("op%0d T%0d ctrl", op, i), obs(), prog_q[i][32:5]);
            check($sformatf("op%0d T%0d alu_op", op, i), cu_if.alu_op, prog_q[i][4:0]);
            check($sformatf("op%0d T%0d clr/run", op, i), {cu_if.clr, cu_if.run}, 2'b01);
            if (i == abort_at) begin
                reset = 1'b1;
                #1;
                check($sformatf("op%0d abort T%0d ctrl", op, i), obs(), 28'h0);
                check($sformatf("op%0d abort clr/run", op), {cu_if.clr, cu_if.run}, 2'b10);
                @(negedge clk);
                reset = 1'b0;
                cu_if.stop = 1'b0;
                #1;
                check("abort hold clr", {cu_if.clr, cu_if.run}, 2'b10);
                return;
            end
        end
        if (op == 27 || stop_at >= 0) begin
            for (int k = 0; k < 2; k++) begin
                @(negedge clk);
                #1;
                check($sformatf("op%0d halted ctrl", op), {obs(), cu_if.alu_op}, 33'h0);
                check($sformatf("op%0d halted clr/run", op), {cu_if.clr, cu_if.run}, 2'b00);
            end
            do_reset();
        end
    endtask

    initial begin
        int op, len, stop_at, abort_at;
        logic con;
        cu_if.stop = 1'b0;
        cu_if.ir = '0;
        cu_if.con_ff = 1'b0;
        do_reset();
        run_instr(3, 1'b0, -1, -1);    // add
        run_instr(0, 1'b0, -1, -1);    // ld
        run_instr(19, 1'b0, -1, -1);   // br not taken
        run_instr(19, 1'b1, -1, -1);   // br taken
        run_instr(15, 1'b0, -1, -1);   // mul
        run_instr(2, 1'b0, 5, -1);     // st with stop raised in T5
        run_instr(27, 1'b0, -1, -1);   // halt
        run_instr(0, 1'b0, -1, 6);     // ld reset in T6
        run_instr(3, 1'b1, -1, -1);
        for (int n = 0; n < 120; n++) begin
            op = int'($urandom_range(0, 31));
            con = 1'($urandom_range(0, 1));
            build_prog(op, con);
            len = prog_q.size();
            stop_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, len - 1)) : -1;
            abort_at = ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, len - 1)) : -1;
            run_instr(op, con, stop_at, abort_at);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
